multi_dataflow_mac_mdc_rr_source: RTL and testbench
===================================================

MULTI_DATAFLOW_MAC_MDC_RR_SOURCE -- requirements
Module: multi_dataflow_mac_mdc_rr_source

Interface
REQ-001 The block SHALL have parameter NB_CH, default 3: number of input stream channels, legal range 1..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: TCDM word and stream data width.
REQ-003 The block SHALL have parameter FD, default 2: per-channel output FIFO depth, minimum 2.
REQ-004 The block SHALL have parameter LEN_W, default 16: transfer-length counter width.
REQ-005 The block SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, reset: synchronous, active-high).
REQ-006 The block SHALL have port clear_i (in, 1): synchronous soft clear.
REQ-007 The block SHALL have port start_i (in, 1): single-cycle job start pulse.
REQ-008 The block SHALL have ports base_addr_i, stride_i and len_i (in, NB_CH*32, NB_CH*32 and NB_CH*LEN_W): per-channel byte base address, signed byte stride and word count.
REQ-009 The block SHALL have ports busy_o (out, 1; job active) and done_o (out, 1; one-cycle completion pulse).
REQ-010 The block SHALL have a TCDM master port: tcdm_req_o (out, 1), tcdm_gnt_i (in, 1), tcdm_add_o (out, 32), tcdm_wen_o (out, 1, constant 1 = read), tcdm_r_data_i (in, DATA_WIDTH), tcdm_r_valid_i (in, 1).
REQ-011 The block SHALL have ports out_valid_o (out, NB_CH), out_data_o (out, NB_CH*DATA_WIDTH) and out_ready_i (in, NB_CH): per-channel stream sources.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DRAIN, and SHALL enter IDLE on reset.
REQ-013 IDLE SHALL go to RUN on start_i and latch all config inputs; start_i SHALL be ignored outside IDLE.
REQ-014 RUN SHALL go to DRAIN once every channel has issued len words; a channel with len=0 SHALL be complete immediately.
REQ-015 DRAIN SHALL go to IDLE when no read is in flight and all FIFOs are empty; done_o SHALL be 1 for exactly the first IDLE cycle after DRAIN.
REQ-016 busy_o SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-017 Channel c SHALL be eligible when it is in RUN, is not complete, and its FIFO occupancy plus in-flight count is less than FD.
REQ-018 Arbitration SHALL be round-robin over eligible channels starting at a pointer; on grant the pointer SHALL move to winner+1 mod NB_CH.
REQ-019 Once tcdm_req_o is asserted, tcdm_add_o and the selected channel SHALL stay stable until tcdm_gnt_i; no channel switch is allowed while a request is ungranted.
REQ-020 The address for channel c, word k, SHALL be base[c] + k*stride[c], held in a 32-bit accumulator that wraps modulo 2^32.
REQ-021 Read data SHALL arrive with tcdm_r_valid_i exactly one cycle after the grant; the granted channel ID SHALL be registered and used to route tcdm_r_data_i into that channel's FIFO.
REQ-022 Each FIFO SHALL be first-word-fall-through: out_valid_o[c] = not empty, and data SHALL pop when valid and ready are both 1.
REQ-023 A FIFO push and pop in the same cycle SHALL keep occupancy unchanged; a push to a full FIFO cannot occur by construction, and an assertion SHALL check this.
REQ-024 Channels SHALL be independent: backpressure on one channel SHALL NOT block requests for the other eligible channels.
REQ-025 Per-channel issued-word counters SHALL be LEN_W bits; len=2^LEN_W-1 SHALL be supported without overflow.
REQ-026 clear_i SHALL force IDLE, flush all FIFOs, zero the counters and the round-robin pointer, and drop tcdm_req_o in the same cycle.
REQ-027 clear_i SHALL NOT produce a done_o pulse.
REQ-028 A tcdm_r_valid_i arriving the cycle after clear_i SHALL be discarded.

Reset
REQ-029 On rst_i, tcdm_req_o, busy_o, done_o and out_valid_o SHALL be 0, and tcdm_add_o SHALL be 0.
REQ-030 On rst_i, the FIFOs, counters and pointer SHALL be cleared; reset SHALL take priority over clear_i and start_i.
REQ-031 rst_i asserted mid-job SHALL abort the job with the same effect as clear_i.

Verification
REQ-032 NB_CH=3, len=(4,4,4), stride=4, bases 0x000/0x100/0x200, gnt always 1, all ready=1 -> the address sequence interleaves 0x000, 0x100, 0x200, 0x004...; done_o pulses once; 12 words are delivered in order per channel.
REQ-033 Channel 1 ready=0 throughout, len=(3,3,3) -> channel 1 stops after FD outstanding plus buffered words; channels 0 and 2 complete; the block stays in RUN or DRAIN until channel 1 ready is raised.
REQ-034 gnt held 0 for 5 cycles with req=1 -> tcdm_add_o and the channel stay constant; the order is unchanged after the grant.
REQ-035 len=(0,0,0) with start at cycle 0 -> RUN at cycle 1, DRAIN at cycle 2, done_o=1 at cycle 3; no TCDM request is made.
REQ-036 base=0xFFFFFFFC, stride=4, len=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-037 clear_i in the cycle after a grant -> the returning r_valid data is dropped, all out_valid_o=0, busy_o=0, and no done_o pulse.

Source files
------------

// File: rtl/multi_dataflow_mac_mdc_rr_source_if.sv
// TCDM read-master bundle: the source drives the request side, memory answers with grant and data.
interface multi_dataflow_mac_mdc_rr_source_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  req;
  logic                  gnt;
  logic [31:0]           add;
  logic                  wen;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  modport master (output req, add, wen, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, output gnt, r_data, r_valid);
endinterface

// File: rtl/multi_dataflow_mac_mdc_rr_source.sv
// Multi-channel strided TCDM reader: round-robin request arbitration feeding per-channel
// first-word-fall-through stream FIFOs.
module multi_dataflow_mac_mdc_rr_source #(
  parameter int unsigned NB_CH      = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FD         = 2,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [NB_CH*32-1:0]           base_addr_i,
  input  logic [NB_CH*32-1:0]           stride_i,
  input  logic [NB_CH*LEN_W-1:0]        len_i,
  output logic                          busy_o,
  output logic                          done_o,
  multi_dataflow_mac_mdc_rr_source_if.master tcdm,
  output logic [NB_CH-1:0]              out_valid_o,
  output logic [NB_CH*DATA_WIDTH-1:0]   out_data_o,
  input  logic [NB_CH-1:0]              out_ready_i
);

  localparam int unsigned CW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int unsigned PW = $clog2(FD);
  localparam int unsigned OW = $clog2(FD + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                r_state, w_state_d;
  logic                  r_done;
  logic [31:0]           r_addr   [NB_CH];
  logic [31:0]           r_stride [NB_CH];
  logic [LEN_W-1:0]      r_len    [NB_CH];
  logic [LEN_W-1:0]      r_cnt    [NB_CH];
  logic [DATA_WIDTH-1:0] r_mem    [NB_CH][FD];
  logic [PW-1:0]         r_wp     [NB_CH];
  logic [PW-1:0]         r_rp     [NB_CH];
  logic [OW-1:0]         r_occ    [NB_CH];
  logic [CW-1:0]         r_ptr, r_pend_ch, r_rv_ch;
  logic                  r_pend, r_rv_pend;

  logic [CW-1:0]         w_sel, w_idx;
  logic [NB_CH-1:0]      w_complete, w_infl, w_elig, w_push, w_pop;
  logic                  w_any, w_req, w_gnt, w_drained;

  always_comb begin
    w_complete = '0;
    w_infl     = '0;
    w_elig     = '0;
    w_push     = '0;
    w_pop      = '0;
    w_drained  = !r_rv_pend;
    for (int c = 0; c < NB_CH; c++) begin
      w_complete[c] = (r_cnt[c] == r_len[c]);
      w_infl[c]     = r_rv_pend && (r_rv_ch == CW'(c));
      // Count the in-flight word so the FIFO can never be over-committed.
      w_elig[c]     = (r_state == StRun) && !w_complete[c] &&
                      ((32'(r_occ[c]) + 32'(w_infl[c])) < FD);
      w_push[c]     = tcdm.r_valid && w_infl[c];
      w_pop[c]      = (r_occ[c] != '0) && out_ready_i[c];
      if (r_occ[c] != '0) w_drained = 1'b0;
    end
  end

  // An ungranted request pins the channel; otherwise search from the round-robin pointer.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_idx = '0;
    if (r_pend) begin
      w_any = 1'b1;
      w_sel = r_pend_ch;
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        w_idx = CW'((32'(r_ptr) + 32'(i)) % NB_CH);
        if (!w_any && w_elig[w_idx]) begin
          w_any = 1'b1;
          w_sel = w_idx;
        end
      end
    end
  end

  assign w_req       = (r_state == StRun) && w_any && !clear_i && !rst_i;
  assign w_gnt       = w_req && tcdm.gnt;
  assign tcdm.req    = w_req;
  assign tcdm.add    = w_req ? r_addr[w_sel] : '0;
  assign tcdm.wen    = 1'b1;
  assign busy_o      = (r_state != StIdle);
  assign done_o      = r_done;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start_i) w_state_d = StRun;
      StRun:   if (&w_complete) w_state_d = StDrain;
      StDrain: if (w_drained) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state   <= StIdle;
      r_done    <= 1'b0;
      r_ptr     <= '0;
      r_pend    <= 1'b0;
      r_pend_ch <= '0;
      r_rv_pend <= 1'b0;
      r_rv_ch   <= '0;
      for (int c = 0; c < NB_CH; c++) begin
        r_addr[c]   <= '0;
        r_stride[c] <= '0;
        r_len[c]    <= '0;
        r_cnt[c]    <= '0;
        r_wp[c]     <= '0;
        r_rp[c]     <= '0;
        r_occ[c]    <= '0;
      end
    end else begin
      r_state   <= w_state_d;
      r_done    <= (r_state == StDrain) && (w_state_d == StIdle);
      r_pend    <= w_req && !tcdm.gnt;
      r_pend_ch <= w_sel;
      r_rv_pend <= w_gnt;
      r_rv_ch   <= w_sel;
      if (w_gnt) r_ptr <= (w_sel == CW'(NB_CH - 1)) ? '0 : w_sel + 1'b1;
      for (int c = 0; c < NB_CH; c++) begin
        if (r_state == StIdle && start_i) begin
          r_addr[c]   <= base_addr_i[c*32 +: 32];
          r_stride[c] <= stride_i[c*32 +: 32];
          r_len[c]    <= len_i[c*LEN_W +: LEN_W];
          r_cnt[c]    <= '0;
        end else if (w_gnt && (w_sel == CW'(c))) begin
          r_addr[c] <= r_addr[c] + r_stride[c];
          r_cnt[c]  <= r_cnt[c] + 1'b1;
        end
        if (w_push[c]) r_wp[c] <= (r_wp[c] == PW'(FD - 1)) ? '0 : r_wp[c] + 1'b1;
        if (w_pop[c])  r_rp[c] <= (r_rp[c] == PW'(FD - 1)) ? '0 : r_rp[c] + 1'b1;
        r_occ[c] <= r_occ[c] + OW'(w_push[c]) - OW'(w_pop[c]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NB_CH; c++) begin
      if (w_push[c]) r_mem[c][r_wp[c]] <= tcdm.r_data;
    end
  end

  always_comb begin
    out_valid_o = '0;
    out_data_o  = '0;
    for (int c = 0; c < NB_CH; c++) begin
      out_valid_o[c]                          = (r_occ[c] != '0);
      out_data_o[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[c][r_rp[c]];
    end
  end

  for (genvar g = 0; g < NB_CH; g++) begin : g_chk
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_push[g] && (r_occ[g] == OW'(FD))));
  end

endmodule

// File: tb/tb_multi_dataflow_mac_mdc_rr_source.sv
// Scoreboard bench: expected words queued per channel at job start, checked as streams pop.
module tb_multi_dataflow_mac_mdc_rr_source;
  localparam int unsigned NB_CH = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned FD    = 2;
  localparam int unsigned LEN_W = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                     rst_i, clear_i, start_i;
  logic [NB_CH*32-1:0]      base_addr_i, stride_i;
  logic [NB_CH*LEN_W-1:0]   len_i;
  logic                     busy_o, done_o;
  logic [NB_CH-1:0]         out_valid_o, out_ready_i;
  logic [NB_CH*DW-1:0]      out_data_o;

  multi_dataflow_mac_mdc_rr_source_if #(.DATA_WIDTH(DW)) tcdm ();

  multi_dataflow_mac_mdc_rr_source #(
    .NB_CH(NB_CH), .DATA_WIDTH(DW), .FD(FD), .LEN_W(LEN_W)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tcdm        (tcdm),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [NB_CH][$];
  logic [31:0] gq[$];
  logic        pend_rv, force_rv, prev_wait, chk_order;
  logic [31:0] pend_data, prev_add;
  int          hold_left, done_cnt, req_cnt;
  int          grants [4];
  logic        s_busy, s_done, s_req;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC3C3_5A5A;
  endfunction

  // One clock cycle; entered and left at posedge+1.
  task automatic step();
    logic [31:0] a;
    tcdm.r_valid = pend_rv || force_rv;
    tcdm.r_data  = pend_rv ? pend_data : 32'hDEAD_BEEF;
    tcdm.gnt     = 1'b0;
    #1;
    s_busy = busy_o;
    s_done = done_o;
    s_req  = tcdm.req;
    if (done_o) done_cnt++;
    for (int c = 0; c < NB_CH; c++) begin
      if (out_valid_o[c] && out_ready_i[c]) begin
        if (exp_q[c].size() == 0) check_eq("unexp_pop", 32'(c), 32'hFFFF_FFFF);
        else check_eq("data", out_data_o[c*DW +: DW], exp_q[c].pop_front());
      end
    end
    if (prev_wait && !clear_i) begin
      check_eq("hold_req", 32'(tcdm.req), 32'd1);
      check_eq("hold_add", tcdm.add, prev_add);
    end
    pend_rv = 1'b0;
    if (tcdm.req) begin
      req_cnt++;
      if (hold_left > 0) hold_left--;
      else tcdm.gnt = 1'b1;
      if (tcdm.gnt) begin
        a = tcdm.add;
        grants[int'(a[9:8])]++;
        if (chk_order) begin
          if (gq.size() == 0) check_eq("addr_extra", a, 32'hFFFF_FFFF);
          else check_eq("addr", a, gq.pop_front());
        end
        pend_rv   = 1'b1;
        pend_data = mem_f(a);
      end
    end
    prev_wait = tcdm.req && !tcdm.gnt;
    prev_add  = tcdm.add;
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic do_clr, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] st,
                           input int l0, input int l1, input int l2);
    logic [31:0] b [NB_CH];
    int          l [NB_CH];
    if (do_clr) begin
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
    end
    for (int c = 0; c < NB_CH; c++) exp_q[c].delete();
    gq.delete();
    done_cnt = 0;
    for (int c = 0; c < 4; c++) grants[c] = 0;
    b[0] = b0; b[1] = b1; b[2] = b2;
    l[0] = l0; l[1] = l1; l[2] = l2;
    for (int c = 0; c < NB_CH; c++) begin
      base_addr_i[c*32 +: 32]     = b[c];
      stride_i[c*32 +: 32]        = st;
      len_i[c*LEN_W +: LEN_W]     = LEN_W'(l[c]);
      for (int k = 0; k < l[c]; k++) exp_q[c].push_back(mem_f(b[c] + 32'(k) * st));
    end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int maxc);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin
      step();
      n++;
    end
    if (done_cnt == 0) check_eq("timeout", 32'd0, 32'd1);
    repeat (3) step();
    check_eq("done_once", 32'(done_cnt), 32'd1);
    check_eq("busy_end", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int n, rq;
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b1;
    base_addr_i = '0; stride_i = '0; len_i = '0; out_ready_i = '1;
    tcdm.gnt = 1'b0; tcdm.r_valid = 1'b0; tcdm.r_data = '0;
    pend_rv = 1'b0; force_rv = 1'b0; prev_wait = 1'b0; chk_order = 1'b0;
    pend_data = '0; prev_add = '0; hold_left = 0; done_cnt = 0; req_cnt = 0;
    for (int c = 0; c < 4; c++) grants[c] = 0;
    repeat (3) @(posedge clk_i);
    #1;
    // Reset wins over a simultaneous start.
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_req", 32'(tcdm.req), 32'd0);
    check_eq("rst_add", tcdm.add, 32'd0);
    check_eq("rst_valid", 32'(out_valid_o), 32'd0);
    rst_i = 1'b0; start_i = 1'b0;
    step();

    // Interleaved three-channel job, everything ready.
    start_job(1'b1, 32'h000, 32'h100, 32'h200, 32'd4, 4, 4, 4);
    chk_order = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < NB_CH; c++) gq.push_back(32'(c) * 32'h100 + 32'(k) * 32'd4);
    run_until_done(200);
    for (int c = 0; c < NB_CH; c++) check_eq("t1_left", 32'(exp_q[c].size()), 32'd0);
    check_eq("t1_addr_left", 32'(gq.size()), 32'd0);

    // Channel 1 back-pressured: others finish, ch1 stalls at FD words.
    chk_order = 1'b0;
    out_ready_i = 3'b101;
    start_job(1'b1, 32'h000, 32'h100, 32'h200, 32'd4, 3, 3, 3);
    repeat (60) step();
    check_eq("bp_busy", 32'(busy_o), 32'd1);
    check_eq("bp_g0", 32'(grants[0]), 32'd3);
    check_eq("bp_g1", 32'(grants[1]), 32'(FD));
    check_eq("bp_g2", 32'(grants[2]), 32'd3);
    check_eq("bp_v1", 32'(out_valid_o[1]), 32'd1);
    check_eq("bp_q0", 32'(exp_q[0].size()), 32'd0);
    check_eq("bp_q2", 32'(exp_q[2].size()), 32'd0);
    out_ready_i = 3'b111;
    run_until_done(100);
    check_eq("bp_q1", 32'(exp_q[1].size()), 32'd0);

    // Grant withheld for five request cycles.
    start_job(1'b1, 32'h000, 32'h100, 32'h200, 32'd4, 2, 2, 2);
    hold_left = 5;
    chk_order = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NB_CH; c++) gq.push_back(32'(c) * 32'h100 + 32'(k) * 32'd4);
    run_until_done(100);
    check_eq("hold_used", 32'(hold_left), 32'd0);
    check_eq("hold_addr_left", 32'(gq.size()), 32'd0);

    // All lengths zero: RUN, DRAIN, then done on the third cycle, no requests.
    start_job(1'b1, 32'h000, 32'h100, 32'h200, 32'd4, 0, 0, 0);
    rq = req_cnt;
    step();
    check_eq("z_busy1", 32'(s_busy), 32'd1);
    step();
    check_eq("z_busy2", 32'(s_busy), 32'd1);
    check_eq("z_done2", 32'(s_done), 32'd0);
    step();
    check_eq("z_done3", 32'(s_done), 32'd1);
    check_eq("z_busy3", 32'(s_busy), 32'd0);
    check_eq("z_noreq", 32'(req_cnt - rq), 32'd0);

    // Address accumulator wraps at 2^32.
    start_job(1'b1, 32'hFFFF_FFFC, 32'h100, 32'h200, 32'd4, 2, 0, 0);
    gq.push_back(32'hFFFF_FFFC);
    gq.push_back(32'h0000_0000);
    run_until_done(100);
    check_eq("wrap_addr_left", 32'(gq.size()), 32'd0);
    check_eq("wrap_q0", 32'(exp_q[0].size()), 32'd0);

    // Clear right after a grant drops the returning word, and a stray r_valid after it.
    start_job(1'b1, 32'h000, 32'h100, 32'h200, 32'd4, 4, 4, 4);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < NB_CH; c++) gq.push_back(32'(c) * 32'h100 + 32'(k) * 32'd4);
    n = 0;
    while (grants[0] + grants[1] + grants[2] == 0 && n < 10) begin
      step();
      n++;
    end
    check_eq("clr_gnt_seen", 32'(grants[0] + grants[1] + grants[2] > 0), 32'd1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    check_eq("clr_valid", 32'(out_valid_o), 32'd0);
    check_eq("clr_busy", 32'(busy_o), 32'd0);
    repeat (3) step();
    check_eq("clr_valid2", 32'(out_valid_o), 32'd0);
    check_eq("clr_nodone", 32'(done_cnt), 32'd0);

    // Pointer must restart at channel 0 after the clear.
    start_job(1'b0, 32'h000, 32'h100, 32'h200, 32'd4, 1, 1, 1);
    gq.push_back(32'h000);
    gq.push_back(32'h100);
    gq.push_back(32'h200);
    run_until_done(100);
    check_eq("ptr_addr_left", 32'(gq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
